// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave front end: independent write/read FSMs feeding a shared bridge port with round-robin arbitration.
// Latency: AW/W or AR handshake at T gives a bridge request at T+1; all AXI channels backpressure through their valid/ready pairs.
module axi_lite_slave_if #(
    parameter int DATASIZE = 32,
    parameter int ADDRSIZE = 32
) (
    input  logic                    AXI_clk,
    input  logic                    AXI_rst_n,
    // AXI4-Lite write
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDRSIZE-1:0]     awaddr,
    input  logic [2:0]              awprot,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATASIZE-1:0]     wdata,
    input  logic [DATASIZE/8-1:0]   wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    // AXI4-Lite read
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDRSIZE-1:0]     araddr,
    input  logic [2:0]              arprot,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATASIZE-1:0]     rdata,
    output logic [1:0]              rresp,
    // bridge write
    output logic                    write_valid,
    input  logic                    write_ready,
    output logic [ADDRSIZE-1:0]     write_address,
    output logic [DATASIZE-1:0]     write_data,
    output logic [DATASIZE/8-1:0]   write_strobe,
    output logic [2:0]              write_pprot,
    // bridge read
    output logic                    read_address_valid,
    input  logic                    read_address_ready,
    output logic [ADDRSIZE-1:0]     read_address,
    output logic [2:0]              read_pprot,
    input  logic                    read_data_valid,
    output logic                    read_data_ready,
    input  logic [DATASIZE-1:0]     prdata
);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_ISSUE = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_WAIT  = 2'd2;
    localparam logic [1:0] R_RESP  = 2'd3;

    logic [1:0]            w_state_q, w_state_d;
    logic [1:0]            r_state_q, r_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDRSIZE-1:0]   waddr_q, waddr_d;
    logic [2:0]            wprot_q, wprot_d;
    logic [DATASIZE-1:0]   wdata_q, wdata_d;
    logic [DATASIZE/8-1:0] wstrb_q, wstrb_d;
    logic [ADDRSIZE-1:0]   raddr_q, raddr_d;
    logic [2:0]            rprot_q, rprot_d;
    logic [DATASIZE-1:0]   rdata_q, rdata_d;
    logic                  prio_q, prio_d;      // 0 = write wins a tie, 1 = read wins
    logic                  wlock_q, wlock_d;
    logic                  rlock_q, rlock_d;

    logic w_req, r_req, gnt_w, gnt_r;
    logic aw_hs, w_hs, wr_hs, ra_hs;

    // A granted request keeps its grant until its handshake so the bridge payload never flips mid-request.
    always_comb begin
        w_req = (w_state_q == W_ISSUE);
        r_req = (r_state_q == R_ISSUE);
        gnt_w = w_req && (wlock_q || (!rlock_q && (!r_req || !prio_q)));
        gnt_r = r_req && !gnt_w;
        wr_hs = gnt_w && write_ready;
        ra_hs = gnt_r && read_address_ready;
    end

    assign awready            = (w_state_q == W_IDLE) && !aw_held_q;
    assign wready             = (w_state_q == W_IDLE) && !w_held_q;
    assign aw_hs              = awvalid && awready;
    assign w_hs               = wvalid && wready;
    assign bvalid             = (w_state_q == W_RESP);
    assign bresp              = 2'b00;
    assign write_valid        = gnt_w;
    assign write_address      = waddr_q;
    assign write_data         = wdata_q;
    assign write_strobe       = wstrb_q;
    assign write_pprot        = wprot_q;

    assign arready            = (r_state_q == R_IDLE);
    assign read_address_valid = gnt_r;
    assign read_address       = raddr_q;
    assign read_pprot         = rprot_q;
    assign read_data_ready    = (r_state_q == R_WAIT) && read_data_valid;
    assign rvalid             = (r_state_q == R_RESP);
    assign rdata              = rdata_q;
    assign rresp              = 2'b00;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wprot_d   = wprot_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    waddr_d   = awaddr;
                    wprot_d   = awprot;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    w_state_d = W_ISSUE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            W_ISSUE: if (wr_hs)  w_state_d = W_RESP;
            W_RESP:  if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rprot_d   = rprot_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_state_d = R_ISSUE;
                    raddr_d   = araddr;
                    rprot_d   = arprot;
                end
            end
            R_ISSUE: if (ra_hs) r_state_d = R_WAIT;
            R_WAIT: begin
                if (read_data_valid) begin
                    r_state_d = R_RESP;
                    rdata_d   = prdata;
                end
            end
            default: if (rready) r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        prio_d  = ((wr_hs || ra_hs) && w_req && r_req) ? ~prio_q : prio_q;
        wlock_d = gnt_w && !write_ready;
        rlock_d = gnt_r && !read_address_ready;
    end

    always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
        if (!AXI_rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wprot_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            raddr_q   <= '0;
            rprot_q   <= '0;
            rdata_q   <= '0;
            prio_q    <= 1'b0;
            wlock_q   <= 1'b0;
            rlock_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wprot_q   <= wprot_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            raddr_q   <= raddr_d;
            rprot_q   <= rprot_d;
            rdata_q   <= rdata_d;
            prio_q    <= prio_d;
            wlock_q   <= wlock_d;
            rlock_q   <= rlock_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_if.sv
// Directed bench for axi_lite_slave_if: write/read paths, backpressure, arbitration and reset.
module tb_axi_lite_slave_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic        write_valid, write_ready;
    logic [31:0] write_address, write_data;
    logic [3:0]  write_strobe;
    logic [2:0]  write_pprot, read_pprot;
    logic        read_address_valid, read_address_ready;
    logic [31:0] read_address, prdata;
    logic        read_data_valid, read_data_ready;

    int n_cmp = 0;
    int n_err = 0;
    logic overlap_seen = 1'b0;
    logic exp_read_first [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    axi_lite_slave_if #(.DATASIZE(32), .ADDRSIZE(32)) dut (
        .AXI_clk(clk), .AXI_rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_address(write_address), .write_data(write_data),
        .write_strobe(write_strobe), .write_pprot(write_pprot),
        .read_address_valid(read_address_valid), .read_address_ready(read_address_ready),
        .read_address(read_address), .read_pprot(read_pprot),
        .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
        .prdata(prdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (write_valid && read_address_valid) overlap_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
        arvalid = 0; araddr = 0; arprot = 0; rready = 0;
        write_ready = 0; read_address_ready = 0; read_data_valid = 0; prdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", awready, 1); chk("rst_wready", wready, 1); chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0); chk("rst_rvalid", rvalid, 0);
        chk("rst_wvalid", write_valid, 0); chk("rst_ravalid", read_address_valid, 0);
        chk("rst_rdready", read_data_ready, 0); chk("rst_bresp", bresp, 0); chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0); chk("rst_waddr", write_address, 0); chk("rst_wdata", write_data, 0);
        chk("rst_wstrb", write_strobe, 0); chk("rst_wpprot", write_pprot, 0);
        chk("rst_raddr", read_address, 0); chk("rst_rpprot", read_pprot, 0);
        rst_n = 1'b1;
        tick();

        // AW and W together, bridge ready immediately
        awvalid = 1; awaddr = 32'h10; awprot = 3'b000;
        wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; write_ready = 1;
        #1;
        chk("w1_awready", awready, 1); chk("w1_wready", wready, 1);
        tick();
        awvalid = 0; wvalid = 0;
        #1;
        chk("w1_valid", write_valid, 1); chk("w1_addr", write_address, 32'h10);
        chk("w1_data", write_data, 32'hDEADBEEF); chk("w1_strb", write_strobe, 4'hF);
        chk("w1_awready_busy", awready, 0);
        tick();
        chk("w1_valid_drop", write_valid, 0); chk("w1_bvalid", bvalid, 1); chk("w1_bresp", bresp, 0);
        bready = 1;
        tick();
        chk("w1_bdone", bvalid, 0); chk("w1_idle_awready", awready, 1);

        // W leads AW by three cycles, bridge stalls one cycle
        write_ready = 0;
        wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'h3;
        tick();
        wvalid = 0;
        #1;
        chk("w2_wready_held", wready, 0); chk("w2_awready", awready, 1); chk("w2_novalid", write_valid, 0);
        tick(); tick();
        chk("w2_novalid_late", write_valid, 0);
        awvalid = 1; awaddr = 32'h44; awprot = 3'b010;
        tick();
        awvalid = 0;
        #1;
        chk("w2_valid", write_valid, 1); chk("w2_addr", write_address, 32'h44);
        chk("w2_data", write_data, 32'hCAFEF00D); chk("w2_strb", write_strobe, 4'h3);
        chk("w2_pprot", write_pprot, 3'b010);
        tick();
        chk("w2_hold_valid", write_valid, 1); chk("w2_hold_data", write_data, 32'hCAFEF00D);
        write_ready = 1;
        tick();
        chk("w2_bvalid", bvalid, 1); chk("w2_valid_drop", write_valid, 0);
        tick();
        chk("w2_bdone", bvalid, 0);

        // read with bridge data arriving five cycles after the address handshake
        arvalid = 1; araddr = 32'h20; arprot = 3'b001; read_address_ready = 1; rready = 0;
        #1;
        chk("r1_arready", arready, 1);
        tick();
        arvalid = 0;
        #1;
        chk("r1_ravalid", read_address_valid, 1); chk("r1_raddr", read_address, 32'h20);
        chk("r1_rpprot", read_pprot, 3'b001); chk("r1_no_wvalid", write_valid, 0);
        tick();
        chk("r1_ravalid_drop", read_address_valid, 0); chk("r1_rdready_idle", read_data_ready, 0);
        chk("r1_arready_busy", arready, 0);
        repeat (4) tick();
        chk("r1_rdready_wait", read_data_ready, 0);
        read_data_valid = 1; prdata = 32'h12345678;
        #1;
        chk("r1_rdready_pulse", read_data_ready, 1);
        tick();
        read_data_valid = 0; prdata = 32'h0;
        #1;
        chk("r1_rdready_end", read_data_ready, 0); chk("r1_rvalid", rvalid, 1);
        chk("r1_rdata", rdata, 32'h12345678); chk("r1_rresp", rresp, 0);
        rready = 1;
        tick();
        chk("r1_rdone", rvalid, 0); chk("r1_arready_back", arready, 1);

        // both responses stalled for ten cycles
        bready = 0; rready = 0;
        awvalid = 1; awaddr = 32'h30; wvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        arvalid = 1; araddr = 32'h34;
        tick();
        arvalid = 0;
        tick();
        read_data_valid = 1; prdata = 32'hA5A50F0F;
        tick();
        read_data_valid = 0; prdata = 32'h0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_bvalid", bvalid, 1); chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 32'hA5A50F0F);
            chk("bp_awready", awready, 0); chk("bp_arready", arready, 0);
            tick();
        end
        bready = 1; rready = 1;
        tick();
        chk("bp_bdone", bvalid, 0); chk("bp_rdone", rvalid, 0);

        // simultaneous write and read requests, four rounds
        write_ready = 1; read_address_ready = 1; read_data_valid = 1;
        for (int r = 0; r < 4; r++) begin
            int n;
            awvalid = 1; wvalid = 1; arvalid = 1;
            awaddr = 32'h100 + 32'(r * 4); wdata = 32'(r); araddr = 32'h200 + 32'(r * 4);
            prdata = 32'h5500 + 32'(r);
            tick();
            awvalid = 0; wvalid = 0; arvalid = 0;
            #1;
            if (!exp_read_first[r]) begin
                chk("rr_first_w", write_valid, 1); chk("rr_first_r_off", read_address_valid, 0);
                chk("rr_first_waddr", write_address, 32'h100 + 32'(r * 4));
                tick();
                chk("rr_second_r", read_address_valid, 1); chk("rr_second_w_off", write_valid, 0);
            end else begin
                chk("rr_first_r", read_address_valid, 1); chk("rr_first_w_off", write_valid, 0);
                chk("rr_first_raddr", read_address, 32'h200 + 32'(r * 4));
                tick();
                chk("rr_second_w", write_valid, 1); chk("rr_second_r_off", read_address_valid, 0);
            end
            n = 0;
            while (!(awready && wready && arready && !bvalid && !rvalid) && n < 20) begin
                tick();
                n++;
            end
            chk("rr_idle_in_budget", (n < 20), 1);
        end
        read_data_valid = 0;
        chk("rr_no_overlap", overlap_seen, 0);

        // reset while a write is waiting on the bridge
        write_ready = 0;
        awvalid = 1; awaddr = 32'h60; wvalid = 1; wdata = 32'h99; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        #1;
        chk("rs_valid_before", write_valid, 1);
        #3;
        rst_n = 0;
        #1;
        chk("rs_wvalid", write_valid, 0); chk("rs_awready", awready, 1); chk("rs_wready", wready, 1);
        chk("rs_arready", arready, 1); chk("rs_bvalid", bvalid, 0); chk("rs_rvalid", rvalid, 0);
        chk("rs_ravalid", read_address_valid, 0);
        chk("rs_waddr", write_address, 0); chk("rs_wdata", write_data, 0);
        @(posedge clk);
        #2;
        rst_n = 1; write_ready = 1;
        tick();
        chk("rs_no_resp", bvalid, 0); chk("rs_no_valid", write_valid, 0);
        awvalid = 1; awaddr = 32'h80; wvalid = 1; wdata = 32'h11223344; wstrb = 4'hC;
        tick();
        awvalid = 0; wvalid = 0;
        #1;
        chk("rs_new_valid", write_valid, 1); chk("rs_new_addr", write_address, 32'h80);
        chk("rs_new_data", write_data, 32'h11223344); chk("rs_new_strb", write_strobe, 4'hC);
        tick();
        chk("rs_new_bvalid", bvalid, 1);
        tick();
        chk("rs_new_bdone", bvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_if.md
AXI_LITE_SLAVE_IF -- requirements
Module: axi_lite_slave_if

Interface
REQ-001 SHALL have parameter DATASIZE, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDRSIZE, default 32, address width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- AXI_clk  in  1  sole clock; all state on rising edge.
- AXI_rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have AXI4-Lite write ports.
- awvalid in 1, awready out 1, awaddr in ADDRSIZE, awprot in 3.
- wvalid in 1, wready out 1, wdata in DATASIZE, wstrb in DATASIZE/8.
- bvalid out 1, bready in 1, bresp out 2.
REQ-005 SHALL have AXI4-Lite read ports.
- arvalid in 1, arready out 1, araddr in ADDRSIZE, arprot in 3.
- rvalid out 1, rready in 1, rdata out DATASIZE, rresp out 2.
REQ-006 SHALL have bridge-side write ports.
- write_valid out 1, write_ready in 1.
- write_address out ADDRSIZE, write_data out DATASIZE, write_strobe out DATASIZE/8, write_pprot out 3.
REQ-007 SHALL have bridge-side read ports.
- read_address_valid out 1, read_address_ready in 1, read_address out ADDRSIZE, read_pprot out 3.
- read_data_valid in 1, read_data_ready out 1, prdata in DATASIZE.

Function
REQ-008 SHALL run the write FSM W_IDLE -> W_ISSUE -> W_RESP -> W_IDLE.
- In W_IDLE, AW and W are captured independently.
- awready=1 while AW is not yet held; wready=1 while W is not yet held.
REQ-009 SHALL enter W_ISSUE on the edge where both AW and W are held, whether they arrived in the same cycle or in any order.
- AW and W in the same cycle T -> write_valid=1 at T+1.
REQ-010 In W_ISSUE, SHALL hold write_valid=1 and the write payload stable until write_ready=1 is sampled while granted.
REQ-011 SHALL enter W_RESP on the write_ready handshake edge and drive bvalid=1, bresp=2'b00 until bready=1, then return to W_IDLE.
- awready and wready SHALL be 0 outside W_IDLE.
REQ-012 SHALL run the read FSM R_IDLE -> R_ISSUE -> R_WAIT -> R_RESP -> R_IDLE.
- In R_IDLE, arready=1; araddr and arprot are captured on arvalid.
- arvalid at T -> read_address_valid=1 at T+1.
REQ-013 In R_ISSUE, SHALL hold read_address_valid=1 and read_address/read_pprot stable until read_address_ready=1 while granted, then enter R_WAIT.
REQ-014 In R_WAIT, SHALL drive read_data_ready = read_data_valid combinationally.
- On that cycle, SHALL register prdata into rdata and enter R_RESP.
- read_data_ready SHALL be 0 in all other states.
REQ-015 In R_RESP, SHALL drive rvalid=1, rresp=2'b00, rdata stable until rready=1, then return to R_IDLE; at most one read outstanding.
REQ-016 SHALL never assert write_valid and read_address_valid in the same cycle.
- Arbitration is round-robin between W_ISSUE and R_ISSUE.
- The grant flag resets to write priority and toggles after each completed bridge handshake when both requests were pending.
REQ-017 A pending request SHALL be granted within 2 bridge handshakes (no starvation).
REQ-018 AW/W capture SHALL proceed while the read FSM is busy, and vice versa.

Reset
REQ-019 On AXI_rst_n=0, SHALL immediately set both FSMs to IDLE, clear the held-AW/W flags, and clear the grant flag to write.
REQ-020 Reset values SHALL be as follows.
- awready=1, wready=1, arready=1.
- bvalid=0, rvalid=0, write_valid=0, read_address_valid=0, read_data_ready=0.
- bresp=0, rresp=0, rdata=0, all bridge payload outputs=0.
REQ-021 Reset asserted mid-transaction SHALL abandon it with no response issued.
- The first handshake after deassertion SHALL start a fresh transaction.

Verification
REQ-022 AW/W same cycle (awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF), write_ready=1 -> write_valid 1 cycle later with identical payload; bvalid next cycle, bresp=0.
REQ-023 W 3 cycles before AW -> wready=0 after W capture, write_valid only after AW; payload matches both channels.
REQ-024 arvalid araddr=0x20, read_address_ready=1, read_data_valid after 5 cycles with prdata=0x12345678 -> one-cycle read_data_ready pulse; rvalid next cycle, rdata=0x12345678.
REQ-025 Write and read pending simultaneously, repeated 4 times -> grants alternate W,R,W,R; never both valid in the same cycle.
REQ-026 bready/rready held 0 for 10 cycles -> bvalid/rvalid and rdata stable; awready/arready stay 0.
REQ-027 Reset pulsed during W_ISSUE -> all outputs at reset values; a subsequent write completes normally.
